// File: rtl/i3c_bus_arbiter.sv
// I3C bus-ownership controller.
// Assigns dynamic addresses after reset, then grants the bus to one device at
// a time: IBI requests beat mastership requests, and each class is served
// round-robin from a shared pointer. The owner's data beats pass straight
// through to the bus side with no buffering; a mastership is cut off after
// MAX_BURST accepted beats so no device can hog the bus.
module i3c_bus_arbiter #(
    parameter int         NUM_DEV   = 8,
    parameter int         DATA_W    = 8,
    parameter logic [6:0] ADDR_MIN  = 7'h08,
    parameter logic [6:0] ADDR_MAX  = 7'h7F,
    parameter int         MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DEV-1:0]          dev_mst_req,
    input  logic [NUM_DEV-1:0]          dev_ibi_req,
    input  logic [NUM_DEV-1:0]          dev_valid,
    input  logic [NUM_DEV*DATA_W-1:0]   dev_data,
    output logic [NUM_DEV-1:0]          dev_ready,
    output logic [NUM_DEV-1:0]          grant,
    output logic [2:0]                  state,
    output logic                        bus_valid,
    input  logic                        bus_ready,
    output logic [DATA_W-1:0]           bus_data,
    output logic [6:0]                  bus_addr,
    output logic                        bus_ibi,
    output logic [7:0]                  burst_cnt,
    output logic                        daa_valid,
    output logic [$clog2(NUM_DEV)-1:0]  daa_dev,
    output logic [6:0]                  daa_addr
);

    localparam int DEV_W = $clog2(NUM_DEV);

    // Reject parameter sets that cannot be built.
    if (int'(ADDR_MIN) + NUM_DEV - 1 > int'(ADDR_MAX)) begin : g_addr_range_error
        $error("i3c_bus_arbiter: ADDR_MIN+NUM_DEV-1 exceeds ADDR_MAX");
    end
    if (NUM_DEV < 2 || NUM_DEV > 32) begin : g_num_dev_error
        $error("i3c_bus_arbiter: NUM_DEV must be in 2..32");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_burst_error
        $error("i3c_bus_arbiter: MAX_BURST must be in 1..255");
    end

    typedef enum logic [2:0] {
        ST_DAA           = 3'd0,
        ST_IDLE          = 3'd1,
        ST_MASTERSHIP    = 3'd2,
        ST_DATA_TRANSFER = 3'd3,
        ST_IBI_ACK       = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DEV_W-1:0]   owner_q, owner_d;
    logic [DEV_W-1:0]   rr_q, rr_d;
    logic [NUM_DEV-1:0] grant_q, grant_d;
    logic [7:0]         burst_q, burst_d;
    logic [DEV_W-1:0]   daa_idx_q, daa_idx_d;
    logic               daa_valid_q, daa_valid_d;
    logic [DEV_W-1:0]   daa_dev_q, daa_dev_d;
    logic [6:0]         daa_addr_q, daa_addr_d;
    logic [6:0]         bus_addr_q, bus_addr_d;
    logic [6:0]         addr_q [NUM_DEV];

    logic [DEV_W-1:0]   ibi_pick, mst_pick;
    logic [DATA_W-1:0]  owner_beat;
    logic               in_xfer;
    logic               handshake;
    logic [7:0]         burst_inc;
    logic [6:0]         daa_addr_now;

    // First set bit of req searching upward from ptr+1, wrapping around.
    function automatic logic [DEV_W-1:0] rr_pick(input logic [NUM_DEV-1:0] req,
                                                 input logic [DEV_W-1:0]   ptr);
        logic [DEV_W-1:0] sel;
        logic [DEV_W-1:0] idx;
        logic             found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_DEV; k++) begin
            idx = DEV_W'((int'(ptr) + k) % NUM_DEV);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign ibi_pick     = rr_pick(dev_ibi_req, rr_q);
    assign mst_pick     = rr_pick(dev_mst_req, rr_q);
    assign in_xfer      = (state_q == ST_DATA_TRANSFER) || (state_q == ST_IBI_ACK);
    assign handshake    = bus_valid & bus_ready;
    assign burst_inc    = burst_q + 8'd1;
    assign daa_addr_now = ADDR_MIN + 7'(daa_idx_q);

    // Select the owner's beat with constant slices only.
    always_comb begin
        owner_beat = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (owner_q == DEV_W'(i)) owner_beat = dev_data[i*DATA_W +: DATA_W];
        end
    end

    // Zero-latency passthrough between the owner and the bus side.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and infers a latch.
        bus_valid = 1'b0;
        bus_data  = '0;
        bus_ibi   = 1'b0;
        dev_ready = '0;
        if (in_xfer) begin
            bus_valid          = dev_valid[owner_q];
            bus_data           = owner_beat;
            bus_ibi            = (state_q == ST_IBI_ACK);
            dev_ready[owner_q] = bus_ready;
        end
    end

    // Next-state logic: address assignment, arbitration and release rules.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        burst_d     = burst_q;
        daa_idx_d   = daa_idx_q;
        daa_valid_d = 1'b0;
        daa_dev_d   = daa_dev_q;
        daa_addr_d  = daa_addr_q;
        bus_addr_d  = bus_addr_q;

        case (state_q)
            ST_DAA: begin
                daa_valid_d = 1'b1;
                daa_dev_d   = daa_idx_q;
                daa_addr_d  = daa_addr_now;
                if (daa_idx_q == DEV_W'(NUM_DEV - 1)) begin
                    daa_idx_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    daa_idx_d = daa_idx_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (|dev_ibi_req) begin
                    owner_d           = ibi_pick;
                    rr_d              = ibi_pick;
                    grant_d           = '0;
                    grant_d[ibi_pick] = 1'b1;
                    bus_addr_d        = addr_q[ibi_pick];
                    state_d           = ST_IBI_ACK;
                end else if (|dev_mst_req) begin
                    owner_d           = mst_pick;
                    rr_d              = mst_pick;
                    grant_d           = '0;
                    grant_d[mst_pick] = 1'b1;
                    bus_addr_d        = addr_q[mst_pick];
                    state_d           = ST_MASTERSHIP;
                end
            end

            ST_MASTERSHIP: begin
                if (dev_mst_req[owner_q]) begin
                    burst_d = '0;
                    state_d = ST_DATA_TRANSFER;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_DATA_TRANSFER: begin
                // An accepted beat always counts; a dropped request is only
                // honoured on a cycle without a handshake.
                if (handshake) begin
                    burst_d = burst_inc;
                    if (burst_inc == 8'(MAX_BURST)) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (!dev_mst_req[owner_q]) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_IBI_ACK: begin
                if (handshake) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_DAA;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DAA;
            owner_q     <= '0;
            rr_q        <= DEV_W'(NUM_DEV - 1);
            grant_q     <= '0;
            burst_q     <= '0;
            daa_idx_q   <= '0;
            daa_valid_q <= 1'b0;
            daa_dev_q   <= '0;
            daa_addr_q  <= '0;
            bus_addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            burst_q     <= burst_d;
            daa_idx_q   <= daa_idx_d;
            daa_valid_q <= daa_valid_d;
            daa_dev_q   <= daa_dev_d;
            daa_addr_q  <= daa_addr_d;
            bus_addr_q  <= bus_addr_d;
        end
    end

    // Dynamic address table, written once per device during DAA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is tiny and read right after DAA, so it is
            // reset to keep bus_addr defined; larger memories would not be.
            for (int i = 0; i < NUM_DEV; i++) addr_q[i] <= '0;
        end else if (state_q == ST_DAA) begin
            addr_q[daa_idx_q] <= daa_addr_now;
        end
    end

    assign state     = state_q;
    assign grant     = grant_q;
    assign burst_cnt = burst_q;
    assign daa_valid = daa_valid_q;
    assign daa_dev   = daa_dev_q;
    assign daa_addr  = daa_addr_q;
    assign bus_addr  = bus_addr_q;

endmodule
